timer_seq: RTL and testbench
============================

// Module: timer_seq
// PURPOSE
//  Bus-master sequencer that shares the byte-wide timer peripheral between two requesters.
//  Each requester issues one of four commands: CLEAR, START, STOP or READ.
//  The block arbitrates round-robin and drives the timer's cs_/rw_/addr/idata bus.
//  READ returns a coherent 32-bit count, assembled from byte registers 0..3.
//  Sits between the CPU-side masters and the timer; it is the only driver of the timer bus.
// PARAMETERS
//  ADDR_W   `MEM_ADDR_WIDTH  timer bus address width
//  DATA_W   `DATA_WIDTH      timer bus data width (8; count is 4 bytes)
// PORTS
//  clk      in   1       single clock, all state on posedge
//  rst_     in   1       reset, asynchronous, active-high
//  req0     in   1       requester 0 command request, level, held until done0
//  cmd0     in   2       requester 0 command: 00 CLEAR, 01 START, 10 STOP, 11 READ
//  done0    out  1       1-cycle pulse: requester 0 command complete
//  req1     in   1       requester 1 request (as req0)
//  cmd1     in   2       requester 1 command (as cmd0)
//  done1    out  1       1-cycle pulse: requester 1 command complete
//  rdata    out  32      count captured by the last completed READ
//  running  out  1       shadow of timer enable: set by START, cleared by STOP
//  busy     out  1       high in every state except IDLE
//  t_addr   out  ADDR_W  timer address
//  t_idata  out  DATA_W  timer write data
//  t_odata  in   DATA_W  timer read data (combinational from t_addr)
//  t_cs_    out  1       timer chip select, active-low (`Enable_)
//  t_rw_    out  1       timer `Read / `Write
// BEHAVIOUR
//  Reset (async, any state) forces these values immediately:
//  - state=IDLE, done0=done1=0, rdata=0, running=0, busy=0.
//  - t_cs_=`Disable_, t_rw_=`Read, t_addr=0, t_idata=0, last_grant=1.
//  - An in-flight command is dropped and no done is issued.
//  Arbitration happens in IDLE only; the winner's cmd is latched at the grant edge.
//  - If both reqs are high, the winner is the requester not in last_grant.
//  - After reset, req0 wins the first tie.
//  - last_grant updates on grant.
//  Bus is idle (t_cs_=`Disable_) in IDLE and DONE.
//  Each bus cycle is one clk cycle; writes take effect at the edge ending the cycle.
//  FSM: IDLE, WR, RSTOP, RD0, RD1, RD2, RD3, RSTART, DONE.
//  - IDLE -> WR on CLEAR/START/STOP; -> RSTOP on READ if running; -> RD0 on READ if !running.
//  - WR: addr=4, idata=1 (CLEAR) / 2 (START) / 4 (STOP), `Write. -> DONE.
//  - RSTOP: addr=4, idata=4, `Write -> RD0.
//  - RDk: addr=k, `Read; rdata[8k+7:8k] <= t_odata at the ending edge.
//    RD0->RD1->RD2->RD3; RD3 -> RSTART if the read was entered via RSTOP, else -> DONE.
//  - RSTART: addr=4, idata=2, `Write -> DONE.
//  - DONE: pulse done of the granted requester -> IDLE.
//  running is set at the edge ending WR(START), cleared at WR(STOP); CLEAR and READ leave it unchanged.
//  Latency from the grant edge to the done pulse:
//  - CLEAR/START/STOP: 2 cycles.
//  - READ while stopped: 5 cycles.
//  - READ while running: 7 cycles; the timer misses exactly 5 increments.
//  A requester must drop req the cycle after done; a still-high req is a new command.
//  req and cmd changes outside IDLE are ignored.
//  rdata changes only at RD edges and holds between READs; the last READ overwrites it.
//  Timer counter wrap (0xFFFFFFFF->0) is the timer's concern; rdata is returned unmodified.
// STRUCTURE
//  define.h additions:
//  - TCMD_CLEAR/START/STOP/READ (2-bit).
//  - TMR_CNT0..3 = 0..3, TMR_CTRL = 4.
//  - TMR_CLEAR = 1, TMR_START = 2, TMR_STOP = 4.
//  - FSM state encodings.
//  One sub-module, rr_arb2:
//  - 2-way round-robin arbiter: req[1:0], advance, gnt[1:0], last_grant register.
//  - Main FSM and bus drive stay in timer_seq.
// TESTING (bench instantiates the real timer on the t_* bus)
//  1 Reset -> t_cs_=1, done0/1=0, rdata=0, running=0.
//    Assert rst_ mid-READ at RD2 -> IDLE at once, no done, rdata keeps any partial bytes.
//  2 req0 START, wait 100 cycles, req0 STOP -> running 1 then 0.
//    READ -> rdata = ticks between START and STOP edges (exactly 100 ±1 per timing), done0 after 5 cycles.
//  3 Timer preloaded by 0xFFFFFFF0 ticks and running; req1 READ -> t_cs_ sequence STOP, RD0..3, START.
//    rdata self-consistent (no carry tear), done1 7 cycles after grant.
//  4 req0 and req1 high together, 4 rounds -> grants alternate 0,1,0,1 with one done pulse each.
//    A lone req1 after a req1 grant is still served.
//  5 CLEAR while running -> then READ -> rdata < 10, running stays 1.
//  6 cmd changed while busy -> ignored; the latched command completes.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// rtl/timer_seq_pkg.sv - command codes, timer register map and FSM states for timer_seq
package timer_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        TCMD_CLEAR = 2'b00,
        TCMD_START = 2'b01,
        TCMD_STOP  = 2'b10,
        TCMD_READ  = 2'b11
    } tcmd_e;

    localparam int TMR_CNT0 = 0;
    localparam int TMR_CNT1 = 1;
    localparam int TMR_CNT2 = 2;
    localparam int TMR_CNT3 = 3;
    localparam int TMR_CTRL = 4;

    localparam int TMR_CLEAR = 1;
    localparam int TMR_START = 2;
    localparam int TMR_STOP  = 4;

    localparam logic CS_ENABLE  = 1'b0;
    localparam logic CS_DISABLE = 1'b1;
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR     = 4'd1,
        S_RSTOP  = 4'd2,
        S_RD0    = 4'd3,
        S_RD1    = 4'd4,
        S_RD2    = 4'd5,
        S_RD3    = 4'd6,
        S_RSTART = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    // Control-register value written for a plain (non-READ) command
    function automatic int unsigned ctrl_code(input tcmd_e cmd);
        case (cmd)
            TCMD_CLEAR: ctrl_code = TMR_CLEAR;
            TCMD_START: ctrl_code = TMR_START;
            default:    ctrl_code = TMR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/timer_seq_arb.sv
// rtl/timer_seq_arb.sv - two-way round-robin arbiter; the loser of the previous grant wins ties
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/timer_seq.sv
// rtl/timer_seq.sv - shares the byte-wide timer between two requesters and drives its bus
module timer_seq
    import timer_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req0,
    input  logic [1:0]        cmd0,
    output logic              done0,
    input  logic              req1,
    input  logic [1:0]        cmd1,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic              running,
    output logic              busy,
    output logic [ADDR_W-1:0] t_addr,
    output logic [DATA_W-1:0] t_idata,
    input  logic [DATA_W-1:0] t_odata,
    output logic              t_cs_,
    output logic              t_rw_
);

    state_e     state, state_nx;
    tcmd_e      cmd_q;
    logic       who_q;
    logic       via_stop;
    logic [1:0] gnt;
    logic [1:0] sel_cmd;
    logic       advance;

    assign advance = (state == S_IDLE);
    assign sel_cmd = gnt[1] ? cmd1 : cmd0;
    assign busy    = (state != S_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst_),
        .req     ({req1, req0}),
        .advance (advance),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state    <= S_IDLE;
            cmd_q    <= TCMD_CLEAR;
            who_q    <= 1'b0;
            via_stop <= 1'b0;
            rdata    <= '0;
            running  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        who_q    <= gnt[1];
                        cmd_q    <= tcmd_e'(sel_cmd);
                        via_stop <= running;
                    end
                end
                S_WR: begin
                    if (cmd_q == TCMD_START) begin
                        running <= 1'b1;
                    end else if (cmd_q == TCMD_STOP) begin
                        running <= 1'b0;
                    end
                end
                S_RD0: rdata[0*DATA_W +: DATA_W] <= t_odata;
                S_RD1: rdata[1*DATA_W +: DATA_W] <= t_odata;
                S_RD2: rdata[2*DATA_W +: DATA_W] <= t_odata;
                S_RD3: rdata[3*DATA_W +: DATA_W] <= t_odata;
                default: ;
            endcase
        end
    end

    // A READ of a running timer brackets the byte reads with STOP/START so the four bytes agree
    always_comb begin
        state_nx = state;
        t_cs_    = CS_DISABLE;
        t_rw_    = RW_READ;
        t_addr   = '0;
        t_idata  = '0;
        done0    = 1'b0;
        done1    = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    if (tcmd_e'(sel_cmd) != TCMD_READ) begin
                        state_nx = S_WR;
                    end else begin
                        state_nx = running ? S_RSTOP : S_RD0;
                    end
                end
            end
            S_WR: begin
                t_cs_    = CS_ENABLE;
                t_rw_    = RW_WRITE;
                t_addr   = ADDR_W'(TMR_CTRL);
                t_idata  = DATA_W'(ctrl_code(cmd_q));
                state_nx = S_DONE;
            end
            S_RSTOP: begin
                t_cs_    = CS_ENABLE;
                t_rw_    = RW_WRITE;
                t_addr   = ADDR_W'(TMR_CTRL);
                t_idata  = DATA_W'(TMR_STOP);
                state_nx = S_RD0;
            end
            S_RD0: begin
                t_cs_    = CS_ENABLE;
                t_addr   = ADDR_W'(TMR_CNT0);
                state_nx = S_RD1;
            end
            S_RD1: begin
                t_cs_    = CS_ENABLE;
                t_addr   = ADDR_W'(TMR_CNT1);
                state_nx = S_RD2;
            end
            S_RD2: begin
                t_cs_    = CS_ENABLE;
                t_addr   = ADDR_W'(TMR_CNT2);
                state_nx = S_RD3;
            end
            S_RD3: begin
                t_cs_    = CS_ENABLE;
                t_addr   = ADDR_W'(TMR_CNT3);
                state_nx = via_stop ? S_RSTART : S_DONE;
            end
            S_RSTART: begin
                t_cs_    = CS_ENABLE;
                t_rw_    = RW_WRITE;
                t_addr   = ADDR_W'(TMR_CTRL);
                t_idata  = DATA_W'(TMR_START);
                state_nx = S_DONE;
            end
            S_DONE: begin
                done0    = ~who_q;
                done1    = who_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_seq.sv
// tb/tb_timer_seq.sv - self-checking bench for timer_seq with a byte-wide timer model on its bus
module tb_timer_seq;
    import timer_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  cmd0 = 2'b00, cmd1 = 2'b00;
    logic        done0, done1, running, busy, t_cs_, t_rw_;
    logic [31:0] rdata;
    logic [7:0]  t_addr, t_idata, t_odata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_seq #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_(rst_),
        .req0(req0), .cmd0(cmd0), .done0(done0),
        .req1(req1), .cmd1(cmd1), .done1(done1),
        .rdata(rdata), .running(running), .busy(busy),
        .t_addr(t_addr), .t_idata(t_idata), .t_odata(t_odata),
        .t_cs_(t_cs_), .t_rw_(t_rw_)
    );

    // Timer peripheral: counts on every edge it was enabled before; control writes at address 4
    logic [31:0] tmr_cnt = '0;
    logic        tmr_en = 1'b0;
    logic        preload_req = 1'b0;
    logic [31:0] preload_val = '0;
    int          cyc = 0;
    logic        ctrl_wr;
    assign ctrl_wr = !t_cs_ && !t_rw_ && (t_addr == 8'd4);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload_req) tmr_cnt <= preload_val;
        else if (ctrl_wr && t_idata[0]) tmr_cnt <= '0;
        else if (tmr_en) tmr_cnt <= tmr_cnt + 32'd1;
        if (ctrl_wr && t_idata[1]) tmr_en <= 1'b1;
        else if (ctrl_wr && t_idata[2]) tmr_en <= 1'b0;
    end

    always_comb begin
        case (t_addr)
            8'd0:    t_odata = tmr_cnt[7:0];
            8'd1:    t_odata = tmr_cnt[15:8];
            8'd2:    t_odata = tmr_cnt[23:16];
            8'd3:    t_odata = tmr_cnt[31:24];
            default: t_odata = {7'd0, tmr_en};
        endcase
    end

    // Reference: count = base, plus edges elapsed since edge m_s while enabled
    logic [31:0] m_base = '0;
    int          m_s = 0;
    bit          m_en = 1'b0;
    bit          m_last = 1'b1;

    typedef struct {
        int         r;
        logic [1:0] c;
        int         lat;
        logic       run_after;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] c);
        if (r == 0) begin req0 = v; cmd0 = c; end
        else begin req1 = v; cmd1 = c; end
    endtask

    function automatic logic [7:0] code(input logic [1:0] c);
        case (c)
            TCMD_CLEAR: code = 8'd1;
            TCMD_START: code = 8'd2;
            default:    code = 8'd4;
        endcase
    endfunction

    task automatic run_cmd(input int r, input logic [1:0] c, input int alt_at, input logic [1:0] alt_c,
                           output int lat, output int exp_lat);
        int g;
        bit granted, seen, run;
        int nbus;
        logic [31:0] exp_rd;
        logic [17:0] exp_b, act_b;
        run = m_en;
        exp_lat = (c == TCMD_READ) ? (run ? 7 : 5) : 2;
        nbus = exp_lat - 1;
        granted = 1'b0; seen = 1'b0; lat = 0; g = 0;
        @(negedge clk);
        set_req(r, 1'b1, c);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (!granted && busy) begin granted = 1'b1; g = cyc; end
            if (granted) begin
                lat++;
                if (lat == alt_at) set_req(r, 1'b1, alt_c);
                if (lat > nbus) begin
                    chk("bus_idle_cs", 32'(t_cs_), 32'd1);
                end else begin
                    if (c != TCMD_READ) exp_b = {2'b00, 8'd4, code(c)};
                    else if (run && lat == 1) exp_b = {2'b00, 8'd4, 8'd4};
                    else if (run && lat == 6) exp_b = {2'b00, 8'd4, 8'd2};
                    else exp_b = {2'b01, 8'(run ? lat - 2 : lat - 1), 8'd0};
                    act_b = {t_cs_, t_rw_, t_addr, t_rw_ ? 8'd0 : t_idata};
                    chk("bus_cycle", 32'(act_b), 32'(exp_b));
                end
                if (done0 || done1) begin
                    seen = 1'b1;
                    chk("done_who", 32'({done1, done0}), (r == 1) ? 32'd2 : 32'd1);
                end
            end
        end
        set_req(r, 1'b0, c);
        chk("done_seen", 32'(seen), 32'd1);
        case (c)
            TCMD_CLEAR: begin m_base = '0; m_s = g + 1; end
            TCMD_START: if (!m_en) begin m_s = g + 1; m_en = 1'b1; end
            TCMD_STOP:  if (m_en) begin m_base = m_base + 32'(g + 1 - m_s); m_en = 1'b0; end
            default: begin
                exp_rd = m_en ? m_base + 32'(g + 1 - m_s) : m_base;
                if (m_en) begin m_base = exp_rd; m_s = g + 6; end
                chk("rdata", rdata, exp_rd);
            end
        endcase
        m_last = (r == 1);
        @(negedge clk);
        chk("done_one_cycle", 32'({done1, done0}), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        chk("running", 32'(running), 32'(m_en));
    endtask

    task automatic preload(input logic [31:0] v);
        @(negedge clk);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        m_base = v;
        m_s = cyc;
    endtask

    initial begin
        int lat, elat, nd, w;
        bit got;
        tbl[0] = '{0, TCMD_START, 2, 1'b1};
        tbl[1] = '{1, TCMD_READ,  7, 1'b1};
        tbl[2] = '{0, TCMD_STOP,  2, 1'b0};
        tbl[3] = '{1, TCMD_READ,  5, 1'b0};
        tbl[4] = '{0, TCMD_CLEAR, 2, 1'b0};
        tbl[5] = '{0, TCMD_READ,  5, 1'b0};
        tbl[6] = '{1, TCMD_START, 2, 1'b1};
        tbl[7] = '{0, TCMD_CLEAR, 2, 1'b1};
        tbl[8] = '{1, TCMD_READ,  7, 1'b1};
        tbl[9] = '{1, TCMD_STOP,  2, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(t_cs_), 32'd1);
        chk("rst_rw", 32'(t_rw_), 32'd1);
        chk("rst_addr", 32'(t_addr), 32'd0);
        chk("rst_idata", 32'(t_idata), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_ = 1'b0;

        // Reset in the middle of a READ, during RD2
        @(negedge clk);
        req0 = 1'b1; cmd0 = TCMD_READ;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = busy;
        end
        chk("midrst_granted", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        chk("midrst_at_rd2", 32'(t_addr), 32'd2);
        #1 rst_ = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cs", 32'(t_cs_), 32'd1);
        chk("midrst_done", 32'({done1, done0}), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_ = 1'b0;
        m_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'({done1, done0}), 32'd0);
        end

        // Both requesters held high: grants alternate starting with req0
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; cmd0 = TCMD_CLEAR; cmd1 = TCMD_CLEAR;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            @(negedge clk);
            if (done0 || done1) begin
                w = m_last ? 0 : 1;
                chk("tie_grant", 32'({done1, done0}), (w == 1) ? 32'd2 : 32'd1);
                m_last = (w == 1);
                nd++;
                if (nd == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("tie_rounds", 32'(nd), 32'd4);
        m_base = '0;
        @(negedge clk);
        chk("tie_idle", 32'(busy), 32'd0);
        run_cmd(1, TCMD_CLEAR, 0, 2'b00, lat, elat);
        chk("lone_req1_lat", 32'(lat), 32'd2);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].r, tbl[i].c, 0, 2'b00, lat, elat);
            chk("tbl_lat", 32'(lat), 32'(tbl[i].lat));
            chk("tbl_running", 32'(running), 32'(tbl[i].run_after));
        end

        // START, run for a while, STOP, then READ the elapsed count
        run_cmd(0, TCMD_START, 0, 2'b00, lat, elat);
        repeat (100) @(negedge clk);
        run_cmd(0, TCMD_STOP, 0, 2'b00, lat, elat);
        run_cmd(0, TCMD_READ, 0, 2'b00, lat, elat);
        chk("stopped_read_lat", 32'(lat), 32'd5);

        // Reads across the 32-bit wrap while running
        run_cmd(1, TCMD_START, 0, 2'b00, lat, elat);
        for (int i = 0; i < 3; i++) begin
            preload(32'hFFFF_FFF0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            run_cmd(1, TCMD_READ, 0, 2'b00, lat, elat);
            chk("wrap_read_lat", 32'(lat), 32'd7);
        end

        // CLEAR while running, then READ a small count
        run_cmd(0, TCMD_CLEAR, 0, 2'b00, lat, elat);
        run_cmd(1, TCMD_READ, 0, 2'b00, lat, elat);
        chk("clear_small", 32'(rdata < 32'd10), 32'd1);
        chk("clear_still_running", 32'(running), 32'd1);

        // Command changes while busy are ignored
        run_cmd(0, TCMD_STOP, 0, 2'b00, lat, elat);
        run_cmd(0, TCMD_READ, 2, TCMD_START, lat, elat);
        chk("ignore_cmd_lat", 32'(lat), 32'd5);
        run_cmd(1, TCMD_CLEAR, 1, TCMD_START, lat, elat);
        chk("ignore_cmd_run", 32'(running), 32'd0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_cmd(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 2'b00, lat, elat);
            chk("rand_lat", 32'(lat), 32'(elat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
